// File: rtl/serial_comp_pkg.sv
// serial_comp_pkg
//   Shared types and helpers for the bit-serial magnitude comparator.
//   - state_t   : FSM states (IDLE, SHIFT, DONE)
//   - rel_t     : accumulated word relation (REL_EQ / REL_GT / REL_LT)
//   - bit_rel_t : one-hot relation of a single bit pair {gt, eq, lt}
//   - rel_next  : folds one bit-pair relation into the running word relation
package serial_comp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REL_EQ = 2'b00,
    REL_GT = 2'b01,
    REL_LT = 2'b10
  } rel_t;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } bit_rel_t;

  // Bits arrive LSB first, so any differing bit overrides whatever the
  // lower bits decided; equal bits leave the running relation alone.
  function automatic rel_t rel_next(input rel_t rel, input bit_rel_t r);
    rel_t res;
    res = rel;
    if (r.eq)      res = rel;
    else if (r.gt) res = REL_GT;
    else if (r.lt) res = REL_LT;
    return res;
  endfunction

endpackage

// File: rtl/serial_mag_comp_one_bit_rel.sv
// one_bit_rel
//   Combinational relation of a single bit pair.
//   Ports:
//     a, b   in  : operand bits
//     gt     out : a=1, b=0
//     eq     out : a==b
//     lt     out : a=0, b=1
module one_bit_rel (
  input  logic a,
  input  logic b,
  output logic gt,
  output logic eq,
  output logic lt
);

  assign gt = a & ~b;
  assign eq = ~(a ^ b);
  assign lt = ~a & b;

endmodule

// File: rtl/serial_mag_comp.sv
// serial_mag_comp
//   Bit-serial unsigned magnitude comparator. Operand bit pairs arrive LSB
//   first, one per accepted cycle; the word-level relation is accumulated in
//   rel and published on gt/eq/lt (with a one-cycle done pulse) on the edge
//   that leaves the DONE state.
//
//   Handshake: a bit pair is accepted on a rising edge when valid=1 and the
//   FSM is in SHIFT, or when start=1 (start with valid consumes bit 0). There
//   is no back-pressure: the comparator accepts every qualifying pair.
//
//   Ports:
//     clk, rst_n    : clock, asynchronous active-low reset
//     start         : begin a new word (also aborts a word in flight)
//     valid         : a_bit/b_bit hold a bit pair this cycle
//     a_bit, b_bit  : operand bits, LSB first
//     busy          : FSM is in SHIFT
//     done          : one-cycle pulse when gt/eq/lt update
//     gt, eq, lt    : registered result, held until the next done
//     bit_cnt       : bits accepted so far in the current word
//     state         : FSM state, exposed for observation
module serial_mag_comp
  import serial_comp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             valid,
  input  logic             a_bit,
  input  logic             b_bit,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic [CNT_W-1:0] bit_cnt,
  output state_t           state
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  rel_t             rel_q, rel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q;
  logic             gt_q, eq_q, lt_q;

  logic     pair_gt, pair_eq, pair_lt;
  bit_rel_t pair_rel;

  one_bit_rel u_bit_rel (
    .a  (a_bit),
    .b  (b_bit),
    .gt (pair_gt),
    .eq (pair_eq),
    .lt (pair_lt)
  );

  assign pair_rel = '{gt: pair_gt, eq: pair_eq, lt: pair_lt};

  // Next-state, relation and counter logic. start wins in every state so a
  // word in flight is simply discarded and restarted.
  always_comb begin
    state_d = state_q;
    rel_d   = rel_q;
    cnt_d   = cnt_q;
    if (start) begin
      state_d = SHIFT;
      if (valid) begin
        rel_d = rel_next(REL_EQ, pair_rel);
        cnt_d = CNT_W'(1);
      end else begin
        rel_d = REL_EQ;
        cnt_d = '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        SHIFT: begin
          if (valid) begin
            rel_d = rel_next(rel_q, pair_rel);
            if (cnt_q == LAST_BIT) begin
              state_d = DONE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          rel_d   = REL_EQ;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rel_q   <= REL_EQ;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rel_q   <= rel_d;
      cnt_q   <= cnt_d;
    end
  end

  // Result registers load from the final relation while leaving DONE; the
  // relation register may be cleared by a back-to-back start on that same
  // edge, but the old value is what gets published.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      gt_q   <= 1'b0;
      eq_q   <= 1'b0;
      lt_q   <= 1'b0;
    end else begin
      done_q <= (state_q == DONE);
      if (state_q == DONE) begin
        gt_q <= (rel_q == REL_GT);
        eq_q <= (rel_q == REL_EQ);
        lt_q <= (rel_q == REL_LT);
      end
    end
  end

  assign busy    = (state_q == SHIFT);
  assign done    = done_q;
  assign gt      = gt_q;
  assign eq      = eq_q;
  assign lt      = lt_q;
  assign bit_cnt = cnt_q;
  assign state   = state_q;

endmodule
